// File: rtl/instr_encoder.sv
// RV32IM field packer: encodes one instruction word per accepted request into a DEPTH-entry output FIFO.
// Optional macro IMM_RANGE_CHECK_EN replaces out-of-range immediates with a NOP and raises range_err_o.
module instr_encoder #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        range_err_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [6:0]  OPC_R = 7'b0110011;
    localparam logic [6:0]  OPC_I = 7'b0010011;

    logic [31:0] instr_mem_q [DEPTH];
    logic [31:0] addr_mem_q  [DEPTH];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] addr_q;
    logic        err_q;
    logic [31:0] word_d;
    logic        illegal_d;
    logic        push, pop;

    always_comb begin
        word_d    = NOP;
        illegal_d = 1'b0;
        case (op_i)
            4'd0:  word_d = {7'b0000000, rs2_i, rs1_i, 3'b000, rd_i, OPC_R};
            4'd1:  word_d = {7'b0100000, rs2_i, rs1_i, 3'b000, rd_i, OPC_R};
            4'd2:  word_d = {7'b0000000, rs2_i, rs1_i, 3'b111, rd_i, OPC_R};
            4'd3:  word_d = {7'b0000000, rs2_i, rs1_i, 3'b100, rd_i, OPC_R};
            4'd4:  word_d = {7'b0000000, rs2_i, rs1_i, 3'b001, rd_i, OPC_R};
            4'd5:  word_d = {7'b0000001, rs2_i, rs1_i, 3'b000, rd_i, OPC_R};
            4'd6:  word_d = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_I};
            4'd7:  word_d = {7'b0100000, imm_i[4:0], rs1_i, 3'b101, rd_i, OPC_I};
            4'd8:  word_d = {imm_i[11:0], rs1_i, 3'b010, rd_i, 7'b0000011};
            4'd9:  word_d = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], 7'b0100011};
            4'd10: word_d = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, 3'b000,
                             imm_i[4:1], imm_i[11], 7'b1100011};
            default: illegal_d = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic        range_bad;
    logic        rerr_q;
    logic [31:0] word_chk;

    always_comb begin
        range_bad = 1'b0;
        case (op_i)
            4'd6, 4'd8, 4'd9: range_bad = ($signed(imm_i) < -2048) || ($signed(imm_i) > 2047);
            4'd7:  range_bad = (imm_i > 32'd31);
            4'd10: range_bad = ($signed(imm_i) < -4096) || ($signed(imm_i) > 4094) || imm_i[0];
            default: range_bad = 1'b0;
        endcase
        word_chk = range_bad ? NOP : word_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                 rerr_q <= 1'b0;
        else if (push & range_bad) rerr_q <= 1'b1;
    end
    assign range_err_o = rerr_q;
`else
    logic [31:0] word_chk;
    logic        unused_imm_hi;
    assign word_chk      = word_d;
    assign unused_imm_hi = &{1'b0, imm_i[31:13]};
    assign range_err_o   = 1'b0;
`endif

    assign in_ready_o  = !rst_i && (cnt_q < CW'(DEPTH));
    assign out_valid_o = (cnt_q != '0);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    // Head is gated so an empty FIFO presents zeros rather than stale entries.
    assign instr_o     = out_valid_o ? instr_mem_q[rptr_q] : '0;
    assign addr_o      = out_valid_o ? addr_mem_q[rptr_q]  : '0;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            addr_q <= BASE_ADDR;
            err_q  <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
                addr_q <= addr_q + 32'd4;
                if (illegal_d) err_q <= 1'b1;
            end
            if (pop)
                rptr_q <= (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            if (push && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wptr_q] <= word_chk;
            addr_mem_q[wptr_q]  <= addr_q;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table plus scoreboard of expected {word, address} pairs.
module tb_instr_encoder;
    localparam logic [31:0] BASE = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, err, range_err;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, instr, addr;

    instr_encoder #(.DEPTH(2), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .instr_o(instr), .addr_o(addr),
        .err_o(err), .range_err_o(range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t        tv [18];
    logic [63:0] sb [$];
    logic [31:0] mdl_addr;
    int          n_cmp = 0;
    int          n_err = 0;
`ifdef IMM_RANGE_CHECK_EN
    localparam logic [31:0] EXP_BIG  = 32'h0000_0013;
    localparam logic [31:0] EXP_ODD  = 32'h0000_0013;
    localparam logic        EXP_RERR = 1'b1;
`else
    localparam logic [31:0] EXP_BIG  = 32'h0000_0093;
    localparam logic [31:0] EXP_ODD  = 32'h0000_0163;
    localparam logic        EXP_RERR = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] o, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im, input logic [31:0] exp);
        bit ok = 1'b0;
        int w  = 0;
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; in_valid = 1'b1;
        while (!ok && w < 50) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({exp, mdl_addr});
                mdl_addr = mdl_addr + 32'd4;
                ok = 1'b1;
            end
            @(posedge clk); #1;
            w++;
        end
        in_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    initial begin
        tv[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  32'd0,     32'h003100B3};
        tv[1]  = '{4'd1,  5'd3,  5'd1,  5'd2,  32'd0,     32'h402081B3};
        tv[2]  = '{4'd7,  5'd5,  5'd5,  5'd0,  32'd3,     32'h4032D293};
        tv[3]  = '{4'd2,  5'd4,  5'd5,  5'd6,  32'd0,     32'h0062F233};
        tv[4]  = '{4'd3,  5'd7,  5'd8,  5'd9,  32'd0,     32'h009443B3};
        tv[5]  = '{4'd4,  5'd10, 5'd11, 5'd12, 32'd0,     32'h00C59533};
        tv[6]  = '{4'd5,  5'd13, 5'd14, 5'd15, 32'd0,     32'h02F706B3};
        tv[7]  = '{4'd8,  5'd6,  5'd2,  5'd0,  -32'sd4,   32'hFFC12303};
        tv[8]  = '{4'd9,  5'd31, 5'd1,  5'd2,  32'd8,     32'h0020A423};
        tv[9]  = '{4'd10, 5'd9,  5'd1,  5'd2,  -32'sd4,   32'hFE208EE3};
        tv[10] = '{4'd6,  5'd1,  5'd1,  5'd0,  32'd2047,  32'h7FF08093};
        tv[11] = '{4'd6,  5'd1,  5'd1,  5'd0,  -32'sd2048, 32'h80008093};
        tv[12] = '{4'd10, 5'd0,  5'd0,  5'd0,  32'd4094,  32'h7E000FE3};
        tv[13] = '{4'd7,  5'd1,  5'd1,  5'd0,  32'd31,    32'h41F0D093};
        tv[14] = '{4'd12, 5'd1,  5'd2,  5'd3,  32'd5,     32'h00000013};
        tv[15] = '{4'd6,  5'd1,  5'd0,  5'd0,  32'd5,     32'h00500093};
        tv[16] = '{4'd6,  5'd1,  5'd0,  5'd0,  32'd4096,  EXP_BIG};
        tv[17] = '{4'd10, 5'd0,  5'd0,  5'd0,  32'd3,     EXP_ODD};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        mdl_addr = BASE;

        fork
            forever begin
                @(negedge clk);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_word", instr, 32'hDEAD_BEEF);
                    end else begin
                        logic [63:0] e;
                        e = sb.pop_front();
                        chk("instr", instr, e[63:32]);
                        chk("addr", addr, e[31:0]);
                    end
                end
            end
        join_none

        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_flags", {30'd0, err, range_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);

        // One-cycle latency: head valid right after the accepting edge.
        send(4'd6, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_instr", instr, 32'h00500093);
        chk("lat_addr", addr, BASE);
        chk("err_clear", {31'd0, err}, 32'd0);
        out_ready = 1'b1;

        for (int i = 0; i < 18; i++)
            send(tv[i].op, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].imm, tv[i].exp);
        drain();
        chk("err_sticky", {31'd0, err}, 32'd1);
        chk("range_err", {31'd0, range_err}, {31'd0, EXP_RERR});

        // Backpressure with a full FIFO, then push and pop on the same edge.
        out_ready = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3);
        send(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 32'h402081B3);
        op = 4'd6; rd = 5'd1; rs1 = 5'd0; imm = 32'd5; in_valid = 1'b1;
        @(negedge clk);
        chk("full_not_ready", {31'd0, in_ready}, 32'd0);
        chk("full_head_hold", instr, 32'h003100B3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ready_indep_out", {31'd0, in_ready}, 32'd0);
        send(4'd6, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
        chk("pushpop_valid", {31'd0, out_valid}, 32'd1);
        chk("pushpop_ready", {31'd0, in_ready}, 32'd1);
        chk("pushpop_head", instr, 32'h00500093);
        drain();
        chk("err_still", {31'd0, err}, 32'd1);

        // Asynchronous reset with words queued.
        out_ready = 1'b0;
        send(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h003100B3);
        send(4'd2, 5'd4, 5'd5, 5'd6, 32'd0, 32'h0062F233);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_flags", {30'd0, err, range_err}, 32'd0);
        sb.delete();
        mdl_addr = BASE;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(4'd6, 5'd1, 5'd0, 5'd0, 32'd5, 32'h00500093);
        chk("post_rst_addr", addr, BASE);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
